// File: rtl/l1_dram_arbiter.sv
// l1_dram_arbiter: shares one DRAM port between the I-cache and D-cache.
// A round-robin grant picks one owner, its request is latched onto the
// registered DRAM port, the returning ack is routed back to that owner and a
// one-cycle RELEASE separates consecutive transactions.
//
// Handshake: a cache raises cs (with we/addr/data) and holds it until it sees
// its one-cycle ack pulse. The arbiter samples requests only in IDLE; once
// granted, the latched request is held on the DRAM port until dram_ack, and
// requester inputs are not looked at again until the next IDLE. Read data is
// passed through unconditionally and is valid only while the ack is high.
module l1_dram_arbiter #(
  parameter int addr_width     = 32,
  parameter int mem_data_width = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [addr_width-1:0]     icache_addr,
  input  logic                      icache_cs,
  input  logic                      icache_we,
  input  logic [mem_data_width-1:0] icache_data_i,
  output logic                      icache_ack,
  output logic [mem_data_width-1:0] icache_data_o,
  input  logic [addr_width-1:0]     dcache_addr,
  input  logic                      dcache_cs,
  input  logic                      dcache_we,
  input  logic [mem_data_width-1:0] dcache_data_i,
  output logic                      dcache_ack,
  output logic [mem_data_width-1:0] dcache_data_o,
  output logic [addr_width-1:0]     dram_addr,
  output logic                      dram_cs,
  output logic                      dram_we,
  output logic [mem_data_width-1:0] dram_data_o,
  input  logic                      dram_ack,
  input  logic [mem_data_width-1:0] dram_data_i,
  output logic                      busy,
  output logic                      owner,
  output logic [1:0]                state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic                      owner_q, owner_d;
  logic                      cs_q, cs_d;
  logic                      we_q, we_d;
  logic [addr_width-1:0]     addr_q, addr_d;
  logic [mem_data_width-1:0] wdata_q, wdata_d;

  logic any_req;
  logic grant_sel;  // 0 = I-cache wins, 1 = D-cache wins

  assign any_req = icache_cs | dcache_cs;
  // On contention the requester that did not own the port last time wins;
  // with owner reset to 1 the very first contest goes to the I-cache.
  assign grant_sel = (icache_cs & dcache_cs) ? ~owner_q : dcache_cs;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req)  state_d = BUSY;
      BUSY:    if (dram_ack) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the latched DRAM request and the owner
  always_comb begin
    owner_d = owner_q;
    cs_d    = cs_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = grant_sel;
          cs_d    = 1'b1;
          we_d    = grant_sel ? dcache_we     : icache_we;
          addr_d  = grant_sel ? dcache_addr   : icache_addr;
          wdata_d = grant_sel ? dcache_data_i : icache_data_i;
        end
      end
      BUSY: begin
        if (dram_ack) begin
          cs_d = 1'b0;
          we_d = 1'b0;
        end
      end
      RELEASE: begin
        cs_d = 1'b0;
        we_d = 1'b0;
      end
      default: begin
        cs_d = 1'b0;
        we_d = 1'b0;
      end
    endcase
  end

  // DRAM port and owner registers
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= 1'b1;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // FSM outputs: ack routing only while a transaction is in flight
  always_comb begin
    icache_ack = dram_ack & (state_q == BUSY) & ~owner_q;
    dcache_ack = dram_ack & (state_q == BUSY) &  owner_q;
    busy       = (state_q != IDLE);
    state_o    = state_q;
  end

  assign icache_data_o = dram_data_i;
  assign dcache_data_o = dram_data_i;
  assign dram_cs       = cs_q;
  assign dram_we       = we_q;
  assign dram_addr     = addr_q;
  assign dram_data_o   = wdata_q;
  assign owner         = owner_q;

endmodule

// File: tb/tb_l1_dram_arbiter.sv
// Bench for l1_dram_arbiter: directed requests from both caches, a small
// DRAM responder, and a scoreboard monitor that checks every grant on the
// DRAM port and every ack returned to a cache against expected queues.
module tb_l1_dram_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int GW = 2 + AW + DW;  // {owner, we, addr, data}

  logic          clk;
  logic          rst;
  logic [AW-1:0] icache_addr;
  logic          icache_cs;
  logic          icache_we;
  logic [DW-1:0] icache_data_i;
  logic          icache_ack;
  logic [DW-1:0] icache_data_o;
  logic [AW-1:0] dcache_addr;
  logic          dcache_cs;
  logic          dcache_we;
  logic [DW-1:0] dcache_data_i;
  logic          dcache_ack;
  logic [DW-1:0] dcache_data_o;
  logic [AW-1:0] dram_addr;
  logic          dram_cs;
  logic          dram_we;
  logic [DW-1:0] dram_data_o;
  logic          dram_ack;
  logic [DW-1:0] dram_data_i;
  logic          busy;
  logic          owner;
  logic [1:0]    state_o;

  l1_dram_arbiter #(.addr_width(AW), .mem_data_width(DW)) dut (
    .clk(clk), .rst(rst),
    .icache_addr(icache_addr), .icache_cs(icache_cs), .icache_we(icache_we),
    .icache_data_i(icache_data_i), .icache_ack(icache_ack), .icache_data_o(icache_data_o),
    .dcache_addr(dcache_addr), .dcache_cs(dcache_cs), .dcache_we(dcache_we),
    .dcache_data_i(dcache_data_i), .dcache_ack(dcache_ack), .dcache_data_o(dcache_data_o),
    .dram_addr(dram_addr), .dram_cs(dram_cs), .dram_we(dram_we),
    .dram_data_o(dram_data_o), .dram_ack(dram_ack), .dram_data_i(dram_data_i),
    .busy(busy), .owner(owner), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [GW-1:0] exp_q[$];   // expected grants on the DRAM port, in order
  logic [DW-1:0] iack_q[$];  // expected read lines returned to I-cache
  logic [DW-1:0] dack_q[$];  // expected read lines returned to D-cache
  int n_checks = 0;
  int n_fail   = 0;

  int            model_en  = 1;
  int            ack_delay = 5;
  int            low_cnt   = 0;
  int            last_gap  = 0;
  logic          seen_grant = 1'b0;
  logic          cs_prev    = 1'b0;
  logic [GW-1:0] cur_grant  = '0;

  task automatic check(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  function automatic logic [GW-1:0] grec(input logic o, input logic w,
                                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {o, w, a, d};
  endfunction

  // ---------------- DRAM responder ----------------
  initial begin
    dram_ack    = 1'b0;
    dram_data_i = '0;
    forever begin
      @(negedge clk);
      if (model_en != 0 && dram_cs && !rst) begin
        repeat (ack_delay) @(posedge clk);
        #1;
        dram_ack    = 1'b1;
        dram_data_i = pat(dram_addr);
        @(posedge clk);
        #1;
        dram_ack = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (dram_cs && !cs_prev) begin
      if (seen_grant) check("dram_cs_gap_ge2", {{(GW-1){1'b0}}, (last_gap >= 2 || low_cnt >= 2)}, 1);
      last_gap   = low_cnt;
      low_cnt    = 0;
      seen_grant = 1'b1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_grant: got %h expected none", {owner, dram_we, dram_addr});
      end else begin
        cur_grant = exp_q.pop_front();
        check("grant", {owner, dram_we, dram_addr, dram_data_o}, cur_grant);
      end
    end else if (dram_cs) begin
      check("grant_hold", {owner, dram_we, dram_addr, dram_data_o}, cur_grant);
    end
    if (!dram_cs) low_cnt++;

    if (icache_ack) begin
      check("ack_exclusive_i", {{(GW-1){1'b0}}, dcache_ack}, 0);
      if (iack_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_icache_ack: got 1 expected 0");
      end else begin
        check("icache_ack_data", {{(GW-DW){1'b0}}, icache_data_o}, {{(GW-DW){1'b0}}, iack_q.pop_front()});
      end
    end
    if (dcache_ack) begin
      if (dack_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_dcache_ack: got 1 expected 0");
      end else begin
        check("dcache_ack_data", {{(GW-DW){1'b0}}, dcache_data_o}, {{(GW-DW){1'b0}}, dack_q.pop_front()});
      end
    end
    cs_prev = dram_cs;
  end

  // ---------------- driver tasks ----------------
  task automatic set_i(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    icache_addr = a; icache_we = w; icache_data_i = d; icache_cs = 1'b1;
  endtask

  task automatic clr_i();
    icache_cs = 1'b0; icache_we = 1'b0;
  endtask

  task automatic set_d(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    dcache_addr = a; dcache_we = w; dcache_data_i = d; dcache_cs = 1'b1;
  endtask

  task automatic clr_d();
    dcache_cs = 1'b0; dcache_we = 1'b0;
  endtask

  task automatic wait_ack_i();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!icache_ack && n < 300);
    check("icache_ack_seen", {{(GW-1){1'b0}}, icache_ack}, 1);
  endtask

  task automatic wait_ack_d();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dcache_ack && n < 300);
    check("dcache_ack_seen", {{(GW-1){1'b0}}, dcache_ack}, 1);
  endtask

  task automatic wait_grant();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dram_cs && n < 100);
    check("grant_seen", {{(GW-1){1'b0}}, dram_cs}, 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    logic [DW-1:0] a5_line;
    int n;
    a5_line = {32{8'hA5}};
    rst = 1'b1;
    icache_addr = '0; icache_cs = 1'b0; icache_we = 1'b0; icache_data_i = '0;
    dcache_addr = '0; dcache_cs = 1'b0; dcache_we = 1'b0; dcache_data_i = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dram_cs",   {{(GW-1){1'b0}}, dram_cs}, 0);
    check("rst_dram_we",   {{(GW-1){1'b0}}, dram_we}, 0);
    check("rst_dram_addr", {{(GW-AW){1'b0}}, dram_addr}, 0);
    check("rst_dram_data", {{(GW-DW){1'b0}}, dram_data_o}, 0);
    check("rst_acks",      {{(GW-2){1'b0}}, icache_ack, dcache_ack}, 0);
    check("rst_busy",      {{(GW-1){1'b0}}, busy}, 0);
    check("rst_owner",     {{(GW-1){1'b0}}, owner}, 1);
    check("rst_state",     {{(GW-2){1'b0}}, state_o}, 0);
    step();
    rst = 1'b0;

    // Single D-cache read, DRAM acks 5 cycles after cs
    ack_delay = 5;
    step();
    exp_q.push_back(grec(1'b1, 1'b0, 32'h0000_1240, '0));
    dack_q.push_back(pat(32'h0000_1240));
    set_d(32'h0000_1240, 1'b0, '0);
    @(negedge clk);
    check("grant_lat_cycle_n", {{(GW-1){1'b0}}, dram_cs}, 0);
    @(negedge clk);
    check("grant_lat_cycle_n1", {{(GW-1){1'b0}}, dram_cs}, 1);
    check("single_busy", {{(GW-1){1'b0}}, busy}, 1);
    check("single_addr", {{(GW-AW){1'b0}}, dram_addr}, {{(GW-AW){1'b0}}, 32'h0000_1240});
    n = 0;
    while (!dcache_ack && n < 20) begin
      @(negedge clk);
      n++;
      check("single_no_iack", {{(GW-1){1'b0}}, icache_ack}, 0);
    end
    check("single_ack_latency", n, 5);
    step();
    clr_d();
    @(negedge clk);
    check("release_cs",    {{(GW-1){1'b0}}, dram_cs}, 0);
    check("release_state", {{(GW-2){1'b0}}, state_o}, 2);
    check("release_busy",  {{(GW-1){1'b0}}, busy}, 1);
    check("dack_one_cycle", {{(GW-1){1'b0}}, dcache_ack}, 0);
    @(negedge clk);
    check("back_idle_busy", {{(GW-1){1'b0}}, busy}, 0);

    // Simultaneous requests: I-cache first, D-cache after exactly 2 low cycles
    ack_delay = 3;
    step();
    exp_q.push_back(grec(1'b0, 1'b0, 32'h0000_A000, '0));
    exp_q.push_back(grec(1'b1, 1'b0, 32'h0000_B000, '0));
    iack_q.push_back(pat(32'h0000_A000));
    dack_q.push_back(pat(32'h0000_B000));
    set_i(32'h0000_A000, 1'b0, '0);
    set_d(32'h0000_B000, 1'b0, '0);
    wait_ack_i();
    step();
    clr_i();
    wait_ack_d();
    check("contest_gap_exact", last_gap, 2);
    step();
    clr_d();

    // Continuous contention: 4 transactions each, grants alternate I,D,...
    ack_delay = 2;
    repeat (2) step();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(grec(1'b0, 1'b0, 32'h0000_0100 + 32'(k * 32), '0));
      exp_q.push_back(grec(1'b1, 1'b0, 32'h0000_0800 + 32'(k * 32), '0));
      iack_q.push_back(pat(32'h0000_0100 + 32'(k * 32)));
      dack_q.push_back(pat(32'h0000_0800 + 32'(k * 32)));
    end
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          set_i(32'h0000_0100 + 32'(k * 32), 1'b0, '0);
          wait_ack_i();
          step();
        end
        clr_i();
      end
      begin
        for (int k = 0; k < 4; k++) begin
          set_d(32'h0000_0800 + 32'(k * 32), 1'b0, '0);
          wait_ack_d();
          step();
        end
        clr_d();
      end
    join

    // D-cache write-back while I-cache changes its address mid-BUSY
    ack_delay = 6;
    repeat (2) step();
    exp_q.push_back(grec(1'b1, 1'b1, 32'h2000_0040, a5_line));
    dack_q.push_back(pat(32'h2000_0040));
    set_d(32'h2000_0040, 1'b1, a5_line);
    wait_grant();
    step();
    exp_q.push_back(grec(1'b0, 1'b0, 32'h3000_0100, '0));
    iack_q.push_back(pat(32'h3000_0100));
    set_i(32'h3000_0000, 1'b0, '0);
    step();
    icache_addr = 32'h3000_0100;
    wait_ack_d();
    check("wb_addr_held", {{(GW-AW){1'b0}}, dram_addr}, {{(GW-AW){1'b0}}, 32'h2000_0040});
    check("wb_data_held", {{(GW-DW){1'b0}}, dram_data_o}, {{(GW-DW){1'b0}}, a5_line});
    step();
    clr_d();
    @(negedge clk);
    check("wb_we_release", {{(GW-1){1'b0}}, dram_we}, 0);
    check("wb_cs_release", {{(GW-1){1'b0}}, dram_cs}, 0);
    wait_ack_i();
    step();
    clr_i();

    // Spurious dram_ack in IDLE and in RELEASE
    model_en = 0;
    repeat (3) step();
    dram_ack = 1'b1;
    dram_data_i = pat(32'h0BAD_0000);
    @(negedge clk);
    check("spur_idle_acks", {{(GW-2){1'b0}}, icache_ack, dcache_ack}, 0);
    step();
    dram_ack = 1'b0;
    @(negedge clk);
    check("spur_idle_state", {{(GW-2){1'b0}}, state_o}, 0);
    check("spur_idle_cs",    {{(GW-1){1'b0}}, dram_cs}, 0);
    step();
    exp_q.push_back(grec(1'b1, 1'b0, 32'h0000_4000, '0));
    dack_q.push_back(pat(32'h0000_4000));
    set_d(32'h0000_4000, 1'b0, '0);
    wait_grant();
    step();
    dram_ack = 1'b1;
    dram_data_i = pat(32'h0000_4000);
    step();
    clr_d();
    @(negedge clk);
    check("spur_rel_acks",  {{(GW-2){1'b0}}, icache_ack, dcache_ack}, 0);
    check("spur_rel_state", {{(GW-2){1'b0}}, state_o}, 2);
    step();
    dram_ack = 1'b0;
    @(negedge clk);
    check("spur_rel_next_state", {{(GW-2){1'b0}}, state_o}, 0);

    // Reset during BUSY, late ack ignored, then normal service resumes
    step();
    exp_q.push_back(grec(1'b1, 1'b0, 32'h0000_5000, '0));
    set_d(32'h0000_5000, 1'b0, '0);
    wait_grant();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clr_d();
    @(negedge clk);
    check("rst_busy_cs",    {{(GW-1){1'b0}}, dram_cs}, 0);
    check("rst_busy_busy",  {{(GW-1){1'b0}}, busy}, 0);
    check("rst_busy_owner", {{(GW-1){1'b0}}, owner}, 1);
    check("rst_busy_state", {{(GW-2){1'b0}}, state_o}, 0);
    step();
    dram_ack = 1'b1;
    dram_data_i = pat(32'h0000_5000);
    @(negedge clk);
    check("late_ack_ignored", {{(GW-2){1'b0}}, icache_ack, dcache_ack}, 0);
    step();
    dram_ack = 1'b0;
    @(negedge clk);
    check("late_ack_state", {{(GW-2){1'b0}}, state_o}, 0);
    model_en = 1;
    ack_delay = 4;
    step();
    exp_q.push_back(grec(1'b0, 1'b0, 32'h0000_6000, '0));
    iack_q.push_back(pat(32'h0000_6000));
    set_i(32'h0000_6000, 1'b0, '0);
    wait_ack_i();
    step();
    clr_i();

    // Drain and report
    n = 0;
    while ((exp_q.size() + iack_q.size() + dack_q.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("exp_q_drained",  exp_q.size(), 0);
    check("iack_q_drained", iack_q.size(), 0);
    check("dack_q_drained", dack_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
